// File: rtl/logic_arb.sv
// Two-requester arbiter in front of one shared 32-bit bitwise unit (OR/AND/XOR/ANDN).
// Each operation is accepted in IDLE, computed in EXEC and returned in RESP.
module logic_arb #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  input  logic [1:0]  req0_op_i,
  input  logic [31:0] req0_a_i,
  input  logic [31:0] req0_b_i,
  output logic        req0_ready_o,
  input  logic        req1_valid_i,
  input  logic [1:0]  req1_op_i,
  input  logic [31:0] req1_a_i,
  input  logic [31:0] req1_b_i,
  output logic        req1_ready_o,
  output logic        rsp0_valid_o,
  output logic [31:0] rsp0_data_o,
  input  logic        rsp0_ready_i,
  output logic        rsp1_valid_o,
  output logic [31:0] rsp1_data_o,
  input  logic        rsp1_ready_i,
  output logic        busy_o,
  output logic [15:0] ops_done_o
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        gnt_q, gnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] res_q, res_d;
  logic [15:0] cnt_q, cnt_d;

  logic        any_valid;
  logic        gnt_idx;
  logic [31:0] alu_res;

  // Grant: on a tie, round-robin favours the requester not served last.
  always_comb begin
    any_valid = req0_valid_i | req1_valid_i;
    if (req0_valid_i && req1_valid_i) begin
      gnt_idx = RR_EN ? ~last_q : 1'b0;
    end else begin
      gnt_idx = ~req0_valid_i;
    end
  end

  // The single shared bitwise unit, fed only from the latched operands.
  always_comb begin
    unique case (op_q)
      2'b00:   alu_res = a_q | b_q;
      2'b01:   alu_res = a_q & b_q;
      2'b10:   alu_res = a_q ^ b_q;
      default: alu_res = a_q & ~b_q;
    endcase
  end

  // NOTE: every output and _d signal gets a default first, so no path leaves a latch.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    gnt_d        = gnt_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    cnt_d        = cnt_q;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    rsp0_valid_o = 1'b0;
    rsp1_valid_o = 1'b0;
    rsp0_data_o  = '0;
    rsp1_data_o  = '0;

    unique case (state_q)
      IDLE: begin
        req0_ready_o = any_valid & ~gnt_idx;
        req1_ready_o = any_valid &  gnt_idx;
        if (any_valid) begin
          gnt_d   = gnt_idx;
          op_d    = gnt_idx ? req1_op_i : req0_op_i;
          a_d     = gnt_idx ? req1_a_i  : req0_a_i;
          b_d     = gnt_idx ? req1_b_i  : req0_b_i;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_res;
        state_d = RESP;
      end
      RESP: begin
        rsp0_valid_o = ~gnt_q;
        rsp1_valid_o =  gnt_q;
        rsp0_data_o  = gnt_q ? '0 : res_q;
        rsp1_data_o  = gnt_q ? res_q : '0;
        if (gnt_q ? rsp1_ready_i : rsp0_ready_i) begin
          last_d  = gnt_q;
          cnt_d   = cnt_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o     = (state_q != IDLE);
  assign ops_done_o = cnt_q;

  // NOTE: non-blocking assignments for all flops so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_logic_arb.sv
// Bench for logic_arb: a round-robin and a fixed-priority instance share one stimulus
// stream; expected responses go through a scoreboard queue.
module tb_logic_arb;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        v0, v1, rr0, rr1;
  logic [1:0]  op0, op1;
  logic [31:0] a0, b0, a1, b1;

  logic        r_rdy0, r_rdy1, r_rv0, r_rv1, r_busy;
  logic [31:0] r_rd0, r_rd1;
  logic [15:0] r_cnt;
  logic        f_rdy0, f_rdy1, f_rv0, f_rv1, f_busy;
  logic [31:0] f_rd0, f_rd1;
  logic [15:0] f_cnt;

  always #5 clk = ~clk;

  logic_arb #(.RR_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req0_valid_i(v0), .req0_op_i(op0), .req0_a_i(a0), .req0_b_i(b0), .req0_ready_o(r_rdy0),
    .req1_valid_i(v1), .req1_op_i(op1), .req1_a_i(a1), .req1_b_i(b1), .req1_ready_o(r_rdy1),
    .rsp0_valid_o(r_rv0), .rsp0_data_o(r_rd0), .rsp0_ready_i(rr0),
    .rsp1_valid_o(r_rv1), .rsp1_data_o(r_rd1), .rsp1_ready_i(rr1),
    .busy_o(r_busy), .ops_done_o(r_cnt)
  );

  logic_arb #(.RR_EN(1'b0)) dut_fp (
    .clk_i(clk), .rst_i(rst_i),
    .req0_valid_i(v0), .req0_op_i(op0), .req0_a_i(a0), .req0_b_i(b0), .req0_ready_o(f_rdy0),
    .req1_valid_i(v1), .req1_op_i(op1), .req1_a_i(a1), .req1_b_i(b1), .req1_ready_o(f_rdy1),
    .rsp0_valid_o(f_rv0), .rsp0_data_o(f_rd0), .rsp0_ready_i(rr0),
    .rsp1_valid_o(f_rv1), .rsp1_data_o(f_rd1), .rsp1_ready_i(rr1),
    .busy_o(f_busy), .ops_done_o(f_cnt)
  );

  typedef struct {
    logic        idx;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        m_last = 1'b1;
  logic [15:0] m_cnt  = 16'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      2'b00:   return a | b;
      2'b01:   return a & b;
      2'b10:   return a ^ b;
      default: return a & ~b;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered with the DUTs in IDLE, one step after a rising edge.
  task automatic run_txn(input logic tv0, input logic tv1, input int stall);
    logic g;
    logic fg;
    exp_t e;
    v0 = tv0;
    v1 = tv1;
    g  = (tv0 && tv1) ? ~m_last : ~tv0;
    fg = ~tv0;
    sb_q.push_back('{idx: g, data: g ? ref_op(op1, a1, b1) : ref_op(op0, a0, b0)});
    #1;
    check("ready0", r_rdy0, !g);
    check("ready1", r_rdy1, g);
    check("fp_ready0", f_rdy0, !fg);
    tick();                                   // EXEC
    v0 = 1'b0;
    v1 = 1'b0;
    check("exec_busy", r_busy, 1'b1);
    check("exec_rsp_quiet", {r_rv1, r_rv0}, 2'b00);
    tick();                                   // RESP, accept + 2
    e = sb_q.pop_front();
    for (int i = 0; i <= stall; i++) begin
      check("rsp0_valid", r_rv0, !e.idx);
      check("rsp1_valid", r_rv1, e.idx);
      check("rsp_data", e.idx ? r_rd1 : r_rd0, e.data);
      check("rsp_other_data", e.idx ? r_rd0 : r_rd1, 32'h0);
      check("fp_rsp0_valid", f_rv0, !fg);
      if (i < stall) begin
        if (e.idx) v0 = 1'b1; else v1 = 1'b1;
        #1;
        check("stall_no_accept", {r_rdy1, r_rdy0}, 2'b00);
        check("stall_busy", r_busy, 1'b1);
        tick();
      end
    end
    v0  = 1'b0;
    v1  = 1'b0;
    rr0 = 1'b1;
    rr1 = 1'b1;
    tick();                                   // back in IDLE
    rr0 = 1'b0;
    rr1 = 1'b0;
    m_last = e.idx;
    m_cnt  = m_cnt + 16'd1;
    check("ops_done", r_cnt, m_cnt);
    check("idle_busy", r_busy, 1'b0);
  endtask

  initial begin
    logic [1:0]  ops[4];
    logic [31:0] exp_ops[4];
    rst_i = 1'b1;
    {v0, v1, rr0, rr1} = '0;
    {op0, op1} = '0;
    {a0, b0, a1, b1} = '0;
    tick();
    tick();
    check("rst_busy", r_busy, 1'b0);
    check("rst_ops", r_cnt, 16'h0);
    check("rst_rsp", {r_rv1, r_rv0, r_rdy1, r_rdy0}, 4'h0);
    check("rst_data", r_rd0 | r_rd1, 32'h0);
    rst_i = 1'b0;

    // Single req0 OR with latency and count.
    op0 = 2'b00; a0 = 32'hF0F0_0000; b0 = 32'h0000_0F0F;
    run_txn(1'b1, 1'b0, 0);

    // All four operations, alternating requesters.
    ops     = '{2'b00, 2'b01, 2'b10, 2'b11};
    exp_ops = '{32'hFFFF_0F0F, 32'h0F0F_0000, 32'hF0F0_0F0F, 32'hF0F0_0000};
    for (int i = 0; i < 4; i++) begin
      op0 = ops[i]; a0 = 32'hFFFF_0000; b0 = 32'h0F0F_0F0F;
      op1 = ops[i]; a1 = 32'hFFFF_0000; b1 = 32'h0F0F_0F0F;
      check("ref_table", ref_op(ops[i], a0, b0), exp_ops[i]);
      run_txn(i[0] ? 1'b0 : 1'b1, i[0], 0);
    end

    // Both valid for four transactions: RR alternates, fixed priority stays on req0.
    op0 = 2'b10; a0 = 32'h1234_5678; b0 = 32'hFFFF_0000;
    op1 = 2'b11; a1 = 32'hDEAD_BEEF; b1 = 32'h00FF_00FF;
    m_last = 1'b1;
    check("rr_start_ptr", m_last, dut.last_q);
    for (int i = 0; i < 4; i++) run_txn(1'b1, 1'b1, 0);

    // Response held for five cycles.
    op0 = 2'b01; a0 = 32'hCAFE_F00D; b0 = 32'h0FF0_0FF0;
    run_txn(1'b1, 1'b0, 5);

    // Reset during EXEC discards the operation.
    v0 = 1'b1; op0 = 2'b00; a0 = 32'h1; b0 = 32'h2;
    tick();
    v0 = 1'b0;
    check("pre_rst_busy", r_busy, 1'b1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    m_last = 1'b1;
    m_cnt  = 16'd0;
    check("mid_rst_busy", r_busy, 1'b0);
    check("mid_rst_ops", r_cnt, 16'h0);
    check("mid_rst_rsp", {r_rv1, r_rv0}, 2'b00);
    check("mid_rst_data", r_rd0 | r_rd1, 32'h0);

    // Random traffic, starting in the first cycle after reset.
    for (int t = 0; t < 100; t++) begin
      logic tv0, tv1;
      tv0 = 1'($urandom_range(1));
      tv1 = tv0 ? 1'($urandom_range(1)) : 1'b1;
      op0 = 2'($urandom_range(3)); a0 = $urandom; b0 = $urandom;
      op1 = 2'($urandom_range(3)); a1 = $urandom; b1 = $urandom;
      run_txn(tv0, tv1, int'($urandom_range(3)));
    end
    check("ops_done_100", r_cnt, 16'd100);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
